dfi_upd_lp_ctrl: RTL and testbench
==================================

# dfi_upd_lp_ctrl

Controller-side DFI sideband sequencer that drives the update, PHY-master and low-power handshakes onto the DFI bus, sitting directly upstream of the DFI interface. It arbitrates controller requests (ctrl update, low-power entry/exit) against PHY requests (phyupd, phymstr). By construction it never produces a forbidden DFI combination. It also enforces the DFI response-time rules that the interface assertions check.

## Interface
- TCTRLUPD_MIN, 2: minimum cycles ctrlupd_req is held high.
- TCTRLUPD_MAX, 16: maximum cycles ctrlupd_req is held high.
- TLP_RESP, 7: cycles to wait for lp_*_ack before abandoning the request.
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- init_start  in  1  DFI init in progress; blocks all new handshakes.
- ctrlupd_go  in  1  controller pulse: request a ctrl update.
- lp_go  in  1  controller pulse: request low-power entry.
- lp_wakeup_in  in  6  wakeup code, sampled with lp_go.
- lp_exit  in  1  controller pulse: leave low power.
- ctrlupd_ack, phyupd_req, phymstr_req, lp_ctrl_ack, lp_data_ack  in  1  from the PHY.
- phyupd_type, phymstr_type  in  2  from the PHY; captured, not otherwise interpreted.
- ctrlupd_req, phyupd_ack, phymstr_ack, lp_ctrl_req, lp_data_req  out  1  to the PHY.
- lp_ctrl_wakeup, lp_data_wakeup  out  6  to the PHY.
- state_o  out  3  current FSM state.
- lp_active  out  1  low-power handshake acknowledged and held.
- lp_timeout  out  1  one-cycle pulse when an LP request was abandoned.

## Operation
- FSM states: IDLE, CTRLUPD, PHYUPD, PHYMSTR, LP_REQ, LP_HOLD, LP_EXIT.
- In IDLE with init_start low, requests are serviced in this priority order:
  - phyupd_req, then phymstr_req, then a pending ctrlupd_go, then a pending lp_go.
- ctrlupd_go and lp_go pulses are latched as pending requests.
  - A pending request clears when its handshake starts.
  - While init_start is high, pending requests are held and nothing is asserted.
- CTRLUPD:
  - ctrlupd_req is high from entry.
  - A cycle counter counts from 1.
  - Drop ctrlupd_req when (ctrlupd_ack seen and count ≥ TCTRLUPD_MIN) or count = TCTRLUPD_MAX.
  - Then return to IDLE.
- PHYUPD:
  - phyupd_ack asserts the cycle after entry.
  - It holds while phyupd_req is high.
  - It deasserts the cycle after phyupd_req is seen low, then IDLE.
  - phyupd_type is captured on entry.
- PHYMSTR: identical to PHYUPD, using phymstr_req/phymstr_ack.
- LP_REQ:
  - lp_ctrl_req and lp_data_req are high, wakeup outputs = latched lp_wakeup_in, counter counts.
  - Both acks seen → LP_HOLD.
  - TLP_RESP cycles elapse without both acks → drop both reqs, pulse lp_timeout, go to IDLE.
- LP_HOLD: reqs stay high and lp_active = 1 until lp_exit → LP_EXIT.
- LP_EXIT: both reqs low; wait until both acks are low → IDLE.
- Invariants, true every cycle:
  - phyupd_ack & phymstr_ack = 0.
  - ctrlupd_req & phyupd_ack = 0.
  - init_start & (ctrlupd_req | lp_*_req | phyupd_ack | phymstr_ack) = 0 for any handshake started after init_start rose.

## Timing
- Reset: every output is 0 and state = IDLE. Pending flags, counters and wakeup registers are cleared.
- Reset asserted mid-handshake drops all reqs/acks immediately (asynchronous).
- All outputs are registered.
- phyupd_ack latency: 1 cycle from phyupd_req when IDLE. When busy, latency is the remaining busy time + 1.
- Counters are 5 bits wide. They saturate and never wrap.
- ctrlupd_go and lp_go in the same cycle: both are latched; ctrlupd is served first.
- lp_exit outside LP_HOLD is ignored.
- A go pulse arriving while the same request is already pending is absorbed.

## Configuration
- DFI_SB_CHK_EN defined:
  - Adds output err_o (4 bits, sticky, cleared by reset).
  - bit0: ctrlupd_ack while ctrlupd_req is low.
  - bit1: phyupd_req dropped before phyupd_ack was given.
  - bit2: lp ack without req.
  - bit3: phymstr_req and phyupd_req high together in IDLE.
- DFI_SB_CHK_EN undefined: the err_o port and its logic are absent.

## Structure
- Shared package dfi_sb_pkg holds:
  - the state enum typedef;
  - the width localparams (wakeup = 6, type = 2, counter = 5);
  - the err_o bit-index constants.
- One natural sub-module: dfi_sb_timer, a loadable saturating counter with a terminal flag. It is instanced for both the CTRLUPD and the LP_REQ timers.

## Test plan
- ctrlupd_go with PHY ack at cycle 1 → ctrlupd_req high exactly 2 cycles. With no ack → high exactly 16 cycles.
- phyupd_req rises in IDLE → phyupd_ack high 1 cycle later. Drop req at cycle 10 → ack low at cycle 11.
- phyupd_req during CTRLUPD → ack only after ctrlupd_req falls. ctrlupd_req and phyupd_ack are never both high.
- lp_go with wakeup = 6'h0A and no acks → both reqs high 7 cycles, then low, and lp_timeout pulses.
- lp_go, acks at cycle 2, lp_exit at cycle 20 → lp_active 1 until exit. Reqs fall, and IDLE follows the acks falling.
- init_start high with ctrlupd_go and lp_go → no req for the whole init_start window. ctrlupd then lp are served after init_start falls. Reset mid-LP_HOLD → all outputs 0 immediately.

Source files
------------

// File: rtl/dfi_sb_pkg.sv
// Shared types and constants for the DFI sideband sequencer (dfi_upd_lp_ctrl).
// Holds the state encoding, datapath widths, timing limits and err_o bit indices.
package dfi_sb_pkg;

  localparam int WAKE_W = 6;
  localparam int TYPE_W = 2;
  localparam int CNT_W  = 5;
  localparam int ERR_W  = 4;

  localparam logic [CNT_W-1:0] TCTRLUPD_MIN = 5'd2;
  localparam logic [CNT_W-1:0] TCTRLUPD_MAX = 5'd16;
  localparam logic [CNT_W-1:0] TLP_RESP     = 5'd7;

  localparam int ERR_CTRLUPD_ACK  = 0;
  localparam int ERR_PHYUPD_DROP  = 1;
  localparam int ERR_LP_ACK       = 2;
  localparam int ERR_PHY_BOTH_REQ = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CTRLUPD = 3'd1,
    ST_PHYUPD  = 3'd2,
    ST_PHYMSTR = 3'd3,
    ST_LP_REQ  = 3'd4,
    ST_LP_HOLD = 3'd5,
    ST_LP_EXIT = 3'd6
  } dfi_sb_state_e;

endpackage

// File: rtl/dfi_sb_timer.sv
// Loadable saturating up-counter with a terminal-count flag (cnt == term_val_i).
// Used for the ctrl-update hold window and the low-power response window.
module dfi_sb_timer
  import dfi_sb_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic [CNT_W-1:0] term_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/dfi_upd_lp_ctrl.sv
// DFI sideband sequencer: arbitrates ctrl update / low-power against PHY update / PHY master.
// Define DFI_SB_CHK_EN to add the sticky protocol-error output err_o.
module dfi_upd_lp_ctrl
  import dfi_sb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              init_start_i,
  input  logic              ctrlupd_go_i,
  input  logic              lp_go_i,
  input  logic [WAKE_W-1:0] lp_wakeup_in_i,
  input  logic              lp_exit_i,
  input  logic              ctrlupd_ack_i,
  input  logic              phyupd_req_i,
  input  logic              phymstr_req_i,
  input  logic              lp_ctrl_ack_i,
  input  logic              lp_data_ack_i,
  input  logic [TYPE_W-1:0] phyupd_type_i,
  input  logic [TYPE_W-1:0] phymstr_type_i,
  output logic              ctrlupd_req_o,
  output logic              phyupd_ack_o,
  output logic              phymstr_ack_o,
  output logic              lp_ctrl_req_o,
  output logic              lp_data_req_o,
  output logic [WAKE_W-1:0] lp_ctrl_wakeup_o,
  output logic [WAKE_W-1:0] lp_data_wakeup_o,
  output logic [2:0]        state_o,
  output logic              lp_active_o,
  output logic              lp_timeout_o
`ifdef DFI_SB_CHK_EN
  ,
  output logic [ERR_W-1:0]  err_o
`endif
);

  dfi_sb_state_e     state_q, state_d;
  logic              ctrl_pend_q, ctrl_pend_d, lp_pend_q, lp_pend_d;
  logic [WAKE_W-1:0] wake_pend_q, wake_pend_d, wake_out_q, wake_out_d;
  logic              cack_seen_q, cack_seen_d, lca_seen_q, lca_seen_d, lda_seen_q, lda_seen_d;
  logic              creq_q, creq_d, pack_q, pack_d, mack_q, mack_d;
  logic              lreq_q, lreq_d, lact_q, lact_d, lto_q, lto_d;
  logic [TYPE_W-1:0] putype_q, putype_d, pmtype_q, pmtype_d;
  logic              load_ctl, load_lp, ctl_term, lp_term;
  logic [CNT_W-1:0]  ctl_cnt, lp_cnt;

  dfi_sb_timer u_ctl_timer (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .load_i(load_ctl), .inc_i(state_q == ST_CTRLUPD),
    .load_val_i(5'd1), .term_val_i(TCTRLUPD_MAX), .cnt_o(ctl_cnt), .term_o(ctl_term)
  );

  dfi_sb_timer u_lp_timer (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .load_i(load_lp), .inc_i(state_q == ST_LP_REQ),
    .load_val_i(5'd1), .term_val_i(TLP_RESP), .cnt_o(lp_cnt), .term_o(lp_term)
  );

  always_comb begin
    state_d     = state_q;
    ctrl_pend_d = ctrl_pend_q | ctrlupd_go_i;
    lp_pend_d   = lp_pend_q | lp_go_i;
    wake_pend_d = (lp_go_i && !lp_pend_q) ? lp_wakeup_in_i : wake_pend_q;
    wake_out_d  = '0;
    cack_seen_d = cack_seen_q;
    lca_seen_d  = lca_seen_q;
    lda_seen_d  = lda_seen_q;
    creq_d      = 1'b0;
    pack_d      = 1'b0;
    mack_d      = 1'b0;
    lreq_d      = 1'b0;
    lact_d      = 1'b0;
    lto_d       = 1'b0;
    putype_d    = putype_q;
    pmtype_d    = pmtype_q;
    load_ctl    = 1'b0;
    load_lp     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // init_start freezes arbitration; pending flags keep accumulating
        if (!init_start_i) begin
          if (phyupd_req_i) begin
            state_d  = ST_PHYUPD;
            pack_d   = 1'b1;
            putype_d = phyupd_type_i;
          end else if (phymstr_req_i) begin
            state_d  = ST_PHYMSTR;
            mack_d   = 1'b1;
            pmtype_d = phymstr_type_i;
          end else if (ctrl_pend_d) begin
            state_d     = ST_CTRLUPD;
            creq_d      = 1'b1;
            ctrl_pend_d = 1'b0;
            cack_seen_d = 1'b0;
            load_ctl    = 1'b1;
          end else if (lp_pend_d) begin
            state_d    = ST_LP_REQ;
            lreq_d     = 1'b1;
            lp_pend_d  = 1'b0;
            lca_seen_d = 1'b0;
            lda_seen_d = 1'b0;
            load_lp    = 1'b1;
            wake_out_d = wake_pend_d;
          end
        end
      end
      ST_CTRLUPD: begin
        cack_seen_d = cack_seen_q | ctrlupd_ack_i;
        if ((cack_seen_d && (ctl_cnt >= TCTRLUPD_MIN)) || ctl_term) state_d = ST_IDLE;
        else                                                        creq_d  = 1'b1;
      end
      ST_PHYUPD: begin
        if (phyupd_req_i) pack_d  = 1'b1;
        else              state_d = ST_IDLE;
      end
      ST_PHYMSTR: begin
        if (phymstr_req_i) mack_d  = 1'b1;
        else               state_d = ST_IDLE;
      end
      ST_LP_REQ: begin
        lca_seen_d = lca_seen_q | lp_ctrl_ack_i;
        lda_seen_d = lda_seen_q | lp_data_ack_i;
        if (lca_seen_d && lda_seen_d) begin
          state_d    = ST_LP_HOLD;
          lreq_d     = 1'b1;
          lact_d     = 1'b1;
          wake_out_d = wake_out_q;
        end else if (lp_term) begin
          state_d = ST_IDLE;
          lto_d   = 1'b1;
        end else begin
          lreq_d     = 1'b1;
          wake_out_d = wake_out_q;
        end
      end
      ST_LP_HOLD: begin
        if (lp_exit_i) begin
          state_d = ST_LP_EXIT;
        end else begin
          lreq_d     = 1'b1;
          lact_d     = 1'b1;
          wake_out_d = wake_out_q;
        end
      end
      ST_LP_EXIT: begin
        if (!lp_ctrl_ack_i && !lp_data_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      ctrl_pend_q <= 1'b0;
      lp_pend_q   <= 1'b0;
      wake_pend_q <= '0;
      wake_out_q  <= '0;
      cack_seen_q <= 1'b0;
      lca_seen_q  <= 1'b0;
      lda_seen_q  <= 1'b0;
      creq_q      <= 1'b0;
      pack_q      <= 1'b0;
      mack_q      <= 1'b0;
      lreq_q      <= 1'b0;
      lact_q      <= 1'b0;
      lto_q       <= 1'b0;
      putype_q    <= '0;
      pmtype_q    <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_pend_q <= ctrl_pend_d;
      lp_pend_q   <= lp_pend_d;
      wake_pend_q <= wake_pend_d;
      wake_out_q  <= wake_out_d;
      cack_seen_q <= cack_seen_d;
      lca_seen_q  <= lca_seen_d;
      lda_seen_q  <= lda_seen_d;
      creq_q      <= creq_d;
      pack_q      <= pack_d;
      mack_q      <= mack_d;
      lreq_q      <= lreq_d;
      lact_q      <= lact_d;
      lto_q       <= lto_d;
      putype_q    <= putype_d;
      pmtype_q    <= pmtype_d;
    end
  end

  assign ctrlupd_req_o    = creq_q;
  assign phyupd_ack_o     = pack_q;
  assign phymstr_ack_o    = mack_q;
  assign lp_ctrl_req_o    = lreq_q;
  assign lp_data_req_o    = lreq_q;
  assign lp_ctrl_wakeup_o = wake_out_q;
  assign lp_data_wakeup_o = wake_out_q;
  assign state_o          = state_q;
  assign lp_active_o      = lact_q;
  assign lp_timeout_o     = lto_q;

  // PHY type codes are captured for observability only
  logic unused_ok;
  assign unused_ok = ^{putype_q, pmtype_q, lp_cnt};

`ifdef DFI_SB_CHK_EN
  logic [ERR_W-1:0] err_q, err_d;
  logic             preq_prev_q;

  always_comb begin
    err_d = err_q;
    if (ctrlupd_ack_i && !creq_q)                     err_d[ERR_CTRLUPD_ACK] = 1'b1;
    if (preq_prev_q && !phyupd_req_i && !pack_q)      err_d[ERR_PHYUPD_DROP] = 1'b1;
    // acks legitimately trail the reqs while draining in LP_EXIT
    if ((state_q != ST_LP_EXIT) && !lreq_q && (lp_ctrl_ack_i || lp_data_ack_i))
                                                      err_d[ERR_LP_ACK] = 1'b1;
    if ((state_q == ST_IDLE) && phyupd_req_i && phymstr_req_i)
                                                      err_d[ERR_PHY_BOTH_REQ] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q       <= '0;
      preq_prev_q <= 1'b0;
    end else begin
      err_q       <= err_d;
      preq_prev_q <= phyupd_req_i;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_dfi_upd_lp_ctrl.sv
// Self-checking bench for dfi_upd_lp_ctrl: a vector table for single-cycle behaviour
// plus directed sequences for the timer windows, init blocking and async reset.
module tb_dfi_upd_lp_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       init_start_i, ctrlupd_go_i, lp_go_i, lp_exit_i;
  logic [5:0] lp_wakeup_in_i;
  logic       ctrlupd_ack_i, phyupd_req_i, phymstr_req_i, lp_ctrl_ack_i, lp_data_ack_i;
  logic [1:0] phyupd_type_i, phymstr_type_i;
  logic       ctrlupd_req_o, phyupd_ack_o, phymstr_ack_o, lp_ctrl_req_o, lp_data_req_o;
  logic [5:0] lp_ctrl_wakeup_o, lp_data_wakeup_o;
  logic [2:0] state_o;
  logic       lp_active_o, lp_timeout_o;
`ifdef DFI_SB_CHK_EN
  logic [3:0] err_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  dfi_upd_lp_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .init_start_i(init_start_i),
    .ctrlupd_go_i(ctrlupd_go_i), .lp_go_i(lp_go_i), .lp_wakeup_in_i(lp_wakeup_in_i),
    .lp_exit_i(lp_exit_i), .ctrlupd_ack_i(ctrlupd_ack_i), .phyupd_req_i(phyupd_req_i),
    .phymstr_req_i(phymstr_req_i), .lp_ctrl_ack_i(lp_ctrl_ack_i), .lp_data_ack_i(lp_data_ack_i),
    .phyupd_type_i(phyupd_type_i), .phymstr_type_i(phymstr_type_i),
    .ctrlupd_req_o(ctrlupd_req_o), .phyupd_ack_o(phyupd_ack_o), .phymstr_ack_o(phymstr_ack_o),
    .lp_ctrl_req_o(lp_ctrl_req_o), .lp_data_req_o(lp_data_req_o),
    .lp_ctrl_wakeup_o(lp_ctrl_wakeup_o), .lp_data_wakeup_o(lp_data_wakeup_o),
    .state_o(state_o), .lp_active_o(lp_active_o), .lp_timeout_o(lp_timeout_o)
`ifdef DFI_SB_CHK_EN
    , .err_o(err_o)
`endif
  );

  // in: {ctrl_go, lp_go, lp_exit, init, cack, preq, mreq, lca, lda}
  // out: {creq, pack, mack, lreq, lact, lto}
  typedef struct {
    logic [8:0] in;
    logic [5:0] wake;
    logic [2:0] st;
    logic [5:0] out;
    logic [5:0] ewake;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [22:0] obs();
    return {state_o, ctrlupd_req_o, phyupd_ack_o, phymstr_ack_o, lp_ctrl_req_o, lp_data_req_o,
            lp_active_o, lp_timeout_o, lp_ctrl_wakeup_o, lp_data_wakeup_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [8:0] in, input logic [5:0] w);
    {ctrlupd_go_i, lp_go_i, lp_exit_i, init_start_i, ctrlupd_ack_i,
     phyupd_req_i, phymstr_req_i, lp_ctrl_ack_i, lp_data_ack_i} = in;
    lp_wakeup_in_i = w;
  endtask

  initial begin
    logic [22:0] e;
    int n, fall, rise, ov;
    logic prev;

    rst_n_i = 1'b0;
    drive(9'b0, 6'h00);
    phyupd_type_i  = 2'd2;
    phymstr_type_i = 2'd1;

    vecs.push_back('{9'b000000000, 6'h00, 3'd0, 6'b000000, 6'h00});
    vecs.push_back('{9'b000001000, 6'h00, 3'd2, 6'b010000, 6'h00});
    vecs.push_back('{9'b000001000, 6'h00, 3'd2, 6'b010000, 6'h00});
    vecs.push_back('{9'b000000000, 6'h00, 3'd0, 6'b000000, 6'h00});
    vecs.push_back('{9'b000000100, 6'h00, 3'd3, 6'b001000, 6'h00});
    vecs.push_back('{9'b000000000, 6'h00, 3'd0, 6'b000000, 6'h00});
    vecs.push_back('{9'b000001100, 6'h00, 3'd2, 6'b010000, 6'h00});
    vecs.push_back('{9'b000000100, 6'h00, 3'd0, 6'b000000, 6'h00});
    vecs.push_back('{9'b000000100, 6'h00, 3'd3, 6'b001000, 6'h00});
    vecs.push_back('{9'b000000000, 6'h00, 3'd0, 6'b000000, 6'h00});
    vecs.push_back('{9'b100000000, 6'h00, 3'd1, 6'b100000, 6'h00});
    vecs.push_back('{9'b000010000, 6'h00, 3'd1, 6'b100000, 6'h00});
    vecs.push_back('{9'b000000000, 6'h00, 3'd0, 6'b000000, 6'h00});
    vecs.push_back('{9'b010000000, 6'h0A, 3'd4, 6'b000100, 6'h0A});
    vecs.push_back('{9'b000000010, 6'h3F, 3'd4, 6'b000100, 6'h0A});
    vecs.push_back('{9'b000000011, 6'h00, 3'd5, 6'b000110, 6'h0A});
    vecs.push_back('{9'b000000011, 6'h00, 3'd5, 6'b000110, 6'h0A});
    vecs.push_back('{9'b001000011, 6'h00, 3'd6, 6'b000000, 6'h00});
    vecs.push_back('{9'b000000011, 6'h00, 3'd6, 6'b000000, 6'h00});
    vecs.push_back('{9'b000000000, 6'h00, 3'd0, 6'b000000, 6'h00});
    vecs.push_back('{9'b001000000, 6'h00, 3'd0, 6'b000000, 6'h00});
    vecs.push_back('{9'b110000000, 6'h15, 3'd1, 6'b100000, 6'h00});
    vecs.push_back('{9'b000010000, 6'h00, 3'd1, 6'b100000, 6'h00});
    vecs.push_back('{9'b000000000, 6'h00, 3'd0, 6'b000000, 6'h00});
    vecs.push_back('{9'b000000000, 6'h00, 3'd4, 6'b000100, 6'h15});
    vecs.push_back('{9'b000000011, 6'h00, 3'd5, 6'b000110, 6'h15});
    vecs.push_back('{9'b001000000, 6'h00, 3'd6, 6'b000000, 6'h00});
    vecs.push_back('{9'b000000000, 6'h00, 3'd0, 6'b000000, 6'h00});

    repeat (3) @(posedge clk_i);
    #1;
    check("reset_outputs", 32'(obs()), 32'd0);
    rst_n_i = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].in, vecs[i].wake);
      step();
      e = {vecs[i].st, vecs[i].out[5:3], vecs[i].out[2], vecs[i].out[2], vecs[i].out[1:0],
           vecs[i].ewake, vecs[i].ewake};
      check($sformatf("vec%0d", i), 32'(obs()), 32'(e));
    end
    drive(9'b0, 6'h00);

    // ctrlupd with no ack: req held for the full max window
    ctrlupd_go_i = 1'b1;
    step();
    ctrlupd_go_i = 1'b0;
    n = 0;
    while (ctrlupd_req_o && n < 40) begin
      n++;
      step();
    end
    check("ctrlupd_noack_len", n, 16);
    check("ctrlupd_noack_idle", state_o, 3'd0);

    // LP request with no acks: abandoned after the response window
    lp_go_i = 1'b1;
    lp_wakeup_in_i = 6'h0A;
    step();
    lp_go_i = 1'b0;
    lp_wakeup_in_i = 6'h00;
    check("lp_to_wakeup", {lp_ctrl_wakeup_o, lp_data_wakeup_o}, {6'h0A, 6'h0A});
    n = 0;
    while (lp_ctrl_req_o && lp_data_req_o && n < 40) begin
      n++;
      step();
    end
    check("lp_to_req_len", n, 7);
    check("lp_to_pulse", {lp_timeout_o, lp_ctrl_req_o, lp_data_req_o, state_o}, {3'b100, 3'd0});
    step();
    check("lp_to_pulse_end", lp_timeout_o, 1'b0);

    // phyupd: ack 1 cycle after req, low 1 cycle after req drop at cycle 10
    phyupd_req_i = 1'b1;
    step();
    check("phyupd_ack_lat", phyupd_ack_o, 1'b1);
    for (int c = 1; c < 10; c++) step();
    phyupd_req_i = 1'b0;
    check("phyupd_ack_cyc10", phyupd_ack_o, 1'b1);
    step();
    check("phyupd_ack_cyc11", {phyupd_ack_o, state_o}, {1'b0, 3'd0});

    // phyupd request while ctrlupd is busy
    ctrlupd_go_i = 1'b1;
    step();
    ctrlupd_go_i = 1'b0;
    phyupd_req_i = 1'b1;
    fall = -1;
    rise = -1;
    ov = 0;
    prev = ctrlupd_req_o;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (ctrlupd_req_o && phyupd_ack_o) ov++;
      if (prev && !ctrlupd_req_o && fall < 0) fall = k;
      if (phyupd_ack_o && rise < 0) rise = k;
      prev = ctrlupd_req_o;
    end
    check("busy_creq_fall", fall, 16);
    check("busy_pack_rise", rise, fall + 1);
    check("busy_no_overlap", ov, 0);
    phyupd_req_i = 1'b0;
    step();
    check("busy_back_idle", state_o, 3'd0);

    // init_start blocks; pending ctrlupd then lp served afterwards, second go absorbed
    init_start_i = 1'b1;
    step();
    ctrlupd_go_i = 1'b1;
    lp_go_i = 1'b1;
    lp_wakeup_in_i = 6'h2A;
    step();
    lp_go_i = 1'b0;
    lp_wakeup_in_i = 6'h00;
    step();
    ctrlupd_go_i = 1'b0;
    ov = 0;
    for (int k = 0; k < 10; k++) begin
      if (ctrlupd_req_o || lp_ctrl_req_o || lp_data_req_o || phyupd_ack_o || phymstr_ack_o) ov++;
      step();
    end
    check("init_no_req", ov, 0);
    init_start_i = 1'b0;
    ctrlupd_ack_i = 1'b1;
    step();
    check("init_ctrlupd_first", {state_o, ctrlupd_req_o}, {3'd1, 1'b1});
    step();
    ctrlupd_ack_i = 1'b0;
    step();
    check("init_ctrlupd_done", {state_o, ctrlupd_req_o}, {3'd0, 1'b0});
    step();
    check("init_lp_next", {state_o, lp_ctrl_req_o, lp_ctrl_wakeup_o}, {3'd4, 1'b1, 6'h2A});
    lp_ctrl_ack_i = 1'b1;
    lp_data_ack_i = 1'b1;
    step();
    lp_ctrl_ack_i = 1'b0;
    lp_data_ack_i = 1'b0;
    lp_exit_i = 1'b1;
    step();
    lp_exit_i = 1'b0;
    step();
    step();
    check("init_go_absorbed", {state_o, ctrlupd_req_o}, {3'd0, 1'b0});

    // async reset in LP_HOLD clears outputs without waiting for a clock
    lp_go_i = 1'b1;
    lp_wakeup_in_i = 6'h11;
    step();
    lp_go_i = 1'b0;
    lp_ctrl_ack_i = 1'b1;
    lp_data_ack_i = 1'b1;
    step();
    check("rst_hold_reached", {state_o, lp_active_o}, {3'd5, 1'b1});
    #2;
    rst_n_i = 1'b0;
    #1;
    check("rst_async_clear", 32'(obs()), 32'd0);
    lp_ctrl_ack_i = 1'b0;
    lp_data_ack_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    step();
    check("rst_after_release", 32'(obs()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
